// File: rtl/seq_binary_to_bcd.sv
// Sequential binary-to-BCD converter: double-dabble at one input bit per clock,
// with a start/ready/valid handshake, optional signed input and overflow detection.
module seq_binary_to_bcd #(
    parameter int N_BITS_IN     = 8,
    parameter int N_BCD_DIG_OUT = 3,
    parameter int N_BITS_OUT    = 4 * N_BCD_DIG_OUT,
    parameter int SIGNED_IN     = 0
) (
    input  logic                  Clk,
    input  logic                  nRst,
    input  logic                  Start,
    input  logic [N_BITS_IN-1:0]  BinNum,
    output logic                  Ready,
    output logic                  Valid,
    output logic [N_BITS_OUT-1:0] BCDNum,
    output logic                  Sign,
    output logic                  Overflow
);

    localparam int CNT_W = $clog2(N_BITS_IN + 1);

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t                state;
    state_t                stateNext;
    logic [N_BITS_IN-1:0]  shiftReg;
    logic [N_BITS_IN-1:0]  shiftNext;
    logic [N_BITS_OUT-1:0] scratch;
    logic [N_BITS_OUT-1:0] adjusted;
    logic [N_BITS_OUT-1:0] scratchNext;
    logic [CNT_W-1:0]      count;
    logic                  carryOut;
    logic                  ovfSticky;
    logic                  signReg;
    logic                  negIn;
    logic [N_BITS_IN-1:0]  magnitude;
    logic                  lastStep;

    // The most negative value negates to itself, which read unsigned is exactly its magnitude.
    always_comb begin
        negIn     = (SIGNED_IN != 0) && BinNum[N_BITS_IN-1];
        magnitude = negIn ? (~BinNum + N_BITS_IN'(1)) : BinNum;
    end

    // A corrected top digit has its MSB set only when it was >= 5, so that bit is a true decimal carry out.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < N_BCD_DIG_OUT; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        carryOut    = adjusted[N_BITS_OUT-1];
        scratchNext = {adjusted[N_BITS_OUT-2:0], shiftReg[N_BITS_IN-1]};
        shiftNext   = {shiftReg[N_BITS_IN-2:0], 1'b0};
        lastStep    = (state == CONVERT) && (count == CNT_W'(1));
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        Ready     = 1'b0;
        case (state)
            IDLE: begin
                Ready = 1'b1;
                if (Start) begin
                    stateNext = CONVERT;
                end
            end
            CONVERT: begin
                if (lastStep) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            shiftReg  <= '0;
            scratch   <= '0;
            count     <= '0;
            ovfSticky <= 1'b0;
            signReg   <= 1'b0;
            Valid     <= 1'b0;
            BCDNum    <= '0;
            Sign      <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            Valid <= 1'b0;
            if (state == IDLE) begin
                if (Start) begin
                    shiftReg  <= magnitude;
                    signReg   <= negIn;
                    scratch   <= '0;
                    ovfSticky <= 1'b0;
                    count     <= CNT_W'(N_BITS_IN);
                end
            end else begin
                shiftReg  <= shiftNext;
                scratch   <= scratchNext;
                ovfSticky <= ovfSticky | carryOut;
                count     <= count - CNT_W'(1);
                if (lastStep) begin
                    BCDNum   <= scratchNext;
                    Sign     <= signReg;
                    Overflow <= ovfSticky | carryOut;
                    Valid    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Bench for seq_binary_to_bcd: four differently parameterised instances checked
// against a decimal-arithmetic reference model.
module tb_seq_binary_to_bcd;

    logic        Clk = 1'b0;
    logic        nRst = 1'b0;
    logic        startV[4];
    logic [15:0] binV[4];

    logic        readyA, validA, signA, ovfA;
    logic [11:0] bcdA;
    logic        readyB, validB, signB, ovfB;
    logic [19:0] bcdB;
    logic        readyC, validC, signC, ovfC;
    logic [7:0]  bcdC;
    logic        readyD, validD, signD, ovfD;
    logic [11:0] bcdD;

    logic        readyW[4], validW[4], signW[4], ovfW[4];
    logic [19:0] bcdW[4];

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    seq_binary_to_bcd #(.N_BITS_IN(8), .N_BCD_DIG_OUT(3), .SIGNED_IN(0)) dutA (
        .Clk(Clk), .nRst(nRst), .Start(startV[0]), .BinNum(binV[0][7:0]),
        .Ready(readyA), .Valid(validA), .BCDNum(bcdA), .Sign(signA), .Overflow(ovfA));
    seq_binary_to_bcd #(.N_BITS_IN(16), .N_BCD_DIG_OUT(5), .SIGNED_IN(0)) dutB (
        .Clk(Clk), .nRst(nRst), .Start(startV[1]), .BinNum(binV[1]),
        .Ready(readyB), .Valid(validB), .BCDNum(bcdB), .Sign(signB), .Overflow(ovfB));
    seq_binary_to_bcd #(.N_BITS_IN(8), .N_BCD_DIG_OUT(2), .SIGNED_IN(0)) dutC (
        .Clk(Clk), .nRst(nRst), .Start(startV[2]), .BinNum(binV[2][7:0]),
        .Ready(readyC), .Valid(validC), .BCDNum(bcdC), .Sign(signC), .Overflow(ovfC));
    seq_binary_to_bcd #(.N_BITS_IN(8), .N_BCD_DIG_OUT(3), .SIGNED_IN(1)) dutD (
        .Clk(Clk), .nRst(nRst), .Start(startV[3]), .BinNum(binV[3][7:0]),
        .Ready(readyD), .Valid(validD), .BCDNum(bcdD), .Sign(signD), .Overflow(ovfD));

    assign readyW[0] = readyA; assign validW[0] = validA; assign signW[0] = signA; assign ovfW[0] = ovfA;
    assign readyW[1] = readyB; assign validW[1] = validB; assign signW[1] = signB; assign ovfW[1] = ovfB;
    assign readyW[2] = readyC; assign validW[2] = validC; assign signW[2] = signC; assign ovfW[2] = ovfC;
    assign readyW[3] = readyD; assign validW[3] = validD; assign signW[3] = signD; assign ovfW[3] = ovfD;
    assign bcdW[0] = {8'd0, bcdA};
    assign bcdW[1] = bcdB;
    assign bcdW[2] = {12'd0, bcdC};
    assign bcdW[3] = {8'd0, bcdD};

    function automatic int widthOf(input int k);
        return (k == 1) ? 16 : 8;
    endfunction

    function automatic int digitsOf(input int k);
        return (k == 1) ? 5 : ((k == 2) ? 2 : 3);
    endfunction

    function automatic bit signedOf(input int k);
        return (k == 3);
    endfunction

    // Reference: take the (possibly signed) operand's magnitude, then peel decimal digits with % and /.
    function automatic void refModel(input int k, input logic [15:0] b,
                                     output logic [19:0] eb, output logic es, output logic eo);
        longint unsigned v;
        longint unsigned lim;
        int w;
        w  = widthOf(k);
        v  = longint'(b) & ((longint'(1) << w) - 1);
        es = 1'b0;
        if (signedOf(k) && b[w-1]) begin
            es = 1'b1;
            v  = (longint'(1) << w) - v;
        end
        lim = 1;
        for (int i = 0; i < digitsOf(k); i++) lim = lim * 10;
        eo = (v >= lim);
        eb = '0;
        for (int i = 0; i < digitsOf(k); i++) begin
            eb[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endfunction

    // Drives one Start and waits (bounded) for Valid; called at posedge+1 with the instance idle.
    task automatic convert(input int k, input logic [15:0] b,
                           output logic [19:0] bcd, output logic s, output logic o,
                           output int lat, output int readyLow, output int vcyc, output bit timedOut);
        startV[k] = 1'b1;
        binV[k]   = b;
        @(posedge Clk); #1;
        startV[k] = 1'b0;
        binV[k]   = 16'($urandom);
        lat       = 0;
        readyLow  = 0;
        while (!validW[k] && lat < 40) begin
            if (!readyW[k]) readyLow++;
            @(posedge Clk); #1;
            lat++;
        end
        timedOut = !validW[k];
        bcd  = bcdW[k];
        s    = signW[k];
        o    = ovfW[k];
        vcyc = cyc;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        #3;
        for (int k = 0; k < 4; k++) begin
            assertions++;
            if ({readyW[k], validW[k], bcdW[k], signW[k], ovfW[k]} !== {1'b1, 1'b0, 20'd0, 1'b0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL reset_state inst%0d: got rdy=%b vld=%b bcd=%h sgn=%b ovf=%b, expected rdy=1 vld=0 bcd=0 sgn=0 ovf=0",
                         k, readyW[k], validW[k], bcdW[k], signW[k], ovfW[k]);
            end
        end
        @(posedge Clk); #1;
        nRst = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_max_value();
        logic [19:0] bcd; logic s, o; int lat, rl, vc; bit to;
        convert(0, 16'd255, bcd, s, o, lat, rl, vc, to);
        assertions++;
        if (to || lat != 8 || rl != 8) begin
            failures++;
            $display("[TB] FAIL max_latency: got lat=%0d readyLow=%0d timeout=%0b, expected lat=8 readyLow=8", lat, rl, to);
        end
        assertions++;
        if ({bcd, s, o} !== {20'h00255, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL max_value: got bcd=%h sgn=%b ovf=%b, expected bcd=00255 sgn=0 ovf=0", bcd, s, o);
        end
        assertions++;
        if (readyA !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_with_valid: got %b expected 1", readyA);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] bcd; logic s, o; int lat, rl, vc, prevVc; bit to;
        logic [15:0] vals[3] = '{16'd0, 16'd9, 16'd100};
        logic [19:0] exps[3] = '{20'h000, 20'h009, 20'h100};
        prevVc = 0;
        for (int i = 0; i < 3; i++) begin
            convert(0, vals[i], bcd, s, o, lat, rl, vc, to);
            assertions++;
            if (to || bcd !== exps[i] || s !== 1'b0 || o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_value%0d: got bcd=%h sgn=%b ovf=%b timeout=%0b, expected bcd=%h sgn=0 ovf=0",
                         i, bcd, s, o, to, exps[i]);
            end
            if (i > 0) begin
                assertions++;
                if (vc - prevVc != 9) begin
                    failures++;
                    $display("[TB] FAIL b2b_spacing%0d: got %0d cycles, expected 9", i, vc - prevVc);
                end
            end
            prevVc = vc;
        end
        binV[0] = 16'd77;
        @(posedge Clk); #1;
        assertions++;
        if (validA !== 1'b0 || bcdA !== 12'h100) begin
            failures++;
            $display("[TB] FAIL valid_pulse_hold: got vld=%b bcd=%h, expected vld=0 bcd=100", validA, bcdA);
        end
    endtask

    task automatic test_wide();
        logic [19:0] bcd; logic s, o; int lat, rl, vc; bit to;
        convert(1, 16'd65535, bcd, s, o, lat, rl, vc, to);
        assertions++;
        if (to || lat != 16 || bcd !== 20'h65535 || o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wide_max: got bcd=%h ovf=%b lat=%0d, expected bcd=65535 ovf=0 lat=16", bcd, o, lat);
        end
        convert(1, 16'd10000, bcd, s, o, lat, rl, vc, to);
        assertions++;
        if (to || bcd !== 20'h10000 || o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wide_10000: got bcd=%h ovf=%b, expected bcd=10000 ovf=0", bcd, o);
        end
    endtask

    task automatic test_overflow();
        logic [19:0] bcd; logic s, o; int lat, rl, vc; bit to;
        convert(2, 16'd123, bcd, s, o, lat, rl, vc, to);
        assertions++;
        if (to || bcd !== 20'h23 || o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_123: got bcd=%h ovf=%b, expected bcd=23 ovf=1", bcd, o);
        end
        convert(2, 16'd99, bcd, s, o, lat, rl, vc, to);
        assertions++;
        if (to || bcd !== 20'h99 || o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow_99: got bcd=%h ovf=%b, expected bcd=99 ovf=0", bcd, o);
        end
    endtask

    task automatic test_signed();
        logic [19:0] bcd; logic s, o; int lat, rl, vc; bit to;
        logic [15:0] vals[4] = '{16'h80, 16'hFF, 16'h7F, 16'h00};
        logic [20:0] exps[4] = '{{1'b1, 20'h128}, {1'b1, 20'h001}, {1'b0, 20'h127}, {1'b0, 20'h000}};
        for (int i = 0; i < 4; i++) begin
            convert(3, vals[i], bcd, s, o, lat, rl, vc, to);
            assertions++;
            if (to || {s, bcd} !== exps[i] || o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL signed_%h: got sgn=%b bcd=%h ovf=%b, expected sgn=%b bcd=%h ovf=0",
                         vals[i][7:0], s, bcd, o, exps[i][20], exps[i][19:0]);
            end
        end
    endtask

    task automatic test_abort_reset();
        int valids = 0;
        startV[0] = 1'b1;
        binV[0]   = 16'd200;
        @(posedge Clk); #1;
        startV[0] = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        nRst = 1'b0;
        #1;
        assertions++;
        if ({readyA, validA, bcdA, signA, ovfA} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL abort_reset: got rdy=%b vld=%b bcd=%h sgn=%b ovf=%b, expected rdy=1 vld=0 bcd=000 sgn=0 ovf=0",
                     readyA, validA, bcdA, signA, ovfA);
        end
        @(posedge Clk); #1;
        nRst = 1'b1;
        repeat (12) begin
            @(posedge Clk); #1;
            if (validA) valids++;
        end
        assertions++;
        if (valids != 0 || bcdA !== 12'h000) begin
            failures++;
            $display("[TB] FAIL abort_no_valid: got %0d valids bcd=%h, expected 0 valids bcd=000", valids, bcdA);
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        startV[0] = 1'b1;
        binV[0]   = 16'd200;
        @(posedge Clk); #1;
        binV[0] = 16'd55;
        repeat (3) begin
            @(posedge Clk); #1;
            lat++;
        end
        startV[0] = 1'b0;
        binV[0]   = 16'd31;
        while (!validA && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
        assertions++;
        if (!validA || lat != 8 || bcdA !== 12'h200 || ovfA !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignore_start: got vld=%b lat=%0d bcd=%h ovf=%b, expected vld=1 lat=8 bcd=200 ovf=0",
                     validA, lat, bcdA, ovfA);
        end
    endtask

    task automatic test_random();
        logic [19:0] bcd, eb; logic s, o, es, eo; int lat, rl, vc; bit to;
        logic [15:0] b;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 15; n++) begin
                b = 16'($urandom);
                if (widthOf(k) == 8) b[15:8] = 8'd0;
                refModel(k, b, eb, es, eo);
                convert(k, b, bcd, s, o, lat, rl, vc, to);
                assertions++;
                if (to || lat != widthOf(k) || {bcd, s, o} !== {eb, es, eo}) begin
                    failures++;
                    $display("[TB] FAIL random inst%0d in=%h: got bcd=%h sgn=%b ovf=%b lat=%0d, expected bcd=%h sgn=%b ovf=%b lat=%0d",
                             k, b, bcd, s, o, lat, eb, es, eo, widthOf(k));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            startV[k] = 1'b0;
            binV[k]   = 16'd0;
        end
        test_reset();
        test_max_value();
        test_back_to_back();
        test_wide();
        test_overflow();
        test_signed();
        test_abort_reset();
        test_ignore_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
